// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Round-robin arbiter and sequencer that shares one pipelined
//   binary-to-BCD converter between four requesters.
//
//   Each transaction proceeds as follows:
//   - A request is granted in IDLE.
//   - The operand is registered onto Conv_Bin.
//   - The arbiter waits out the converter latency.
//   - The converter result is captured into Res_BCD.
//   - Done pulses one-hot to the served requester.
//   Operands with bit 15 set skip the converter and complete immediately
//   with Err and a zero result.
//
// Ports
//   Sys_CLK       in   system clock, posedge
//   Sys_RST       in   synchronous active-high reset
//   Req           in   [3:0]  request per requester
//   Data_Bin_Bus  in   [63:0] requester i operand at [16i+15:16i]
//   Done          out  [3:0]  one-cycle one-hot completion pulse
//   Err           out  one-cycle pulse with Done for out-of-range operand
//   Res_BCD       out  [19:0] packed BCD result, held until next Done
//   Busy          out  high whenever not IDLE
//   Conv_Bin      out  [15:0] registered converter operand
//   Conv_BCD      in   [19:0] converter result
module bcd_conv_arbiter #(
  parameter int unsigned CONV_LAT = 2
) (
  input  logic        Sys_CLK,
  input  logic        Sys_RST,
  input  logic [3:0]  Req,
  input  logic [63:0] Data_Bin_Bus,
  output logic [3:0]  Done,
  output logic        Err,
  output logic [19:0] Res_BCD,
  output logic        Busy,
  output logic [15:0] Conv_Bin,
  input  logic [19:0] Conv_BCD
);

  localparam int unsigned CNT_W = ($clog2(CONV_LAT + 1) < 1) ? 1 : $clog2(CONV_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         grant_q, grant_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [19:0]        res_q, res_d;
  logic [15:0]        bin_q, bin_d;

  logic               gnt_valid;
  logic [1:0]         gnt_idx;
  logic [1:0]         cand;
  logic [15:0]        gnt_val;

  // Round-robin search: start one past the last winner and wrap 3->0.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!gnt_valid && Req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_val = Data_Bin_Bus[{gnt_idx, 4'b0000} +: 16];

  // State register
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd3;
      grant_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bin_q   <= bin_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    bin_d   = bin_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          ptr_d   = gnt_idx;
          grant_d = gnt_idx;
          if (gnt_val[15]) begin
            // Out of converter range: complete at once, converter untouched.
            err_d   = 1'b1;
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            bin_d   = gnt_val;
            cnt_d   = CNT_W'(CONV_LAT);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_d   = Conv_BCD;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Done = '0;
    if (state_q == S_DONE) Done[grant_q] = 1'b1;
    Err      = (state_q == S_DONE) && err_q;
    Busy     = (state_q != S_IDLE);
    Res_BCD  = res_q;
    Conv_Bin = bin_q;
  end

endmodule
